// File: rtl/trafik_isik_izleyici.sv
// trafik_isik_izleyici: traffic-light LED monitor; decodes phase, times it in seconds, checks order/windows, latches first fault.
// Ports: clk, rst_n (async, active-low); kirmizi_in/mavi_in/yesil_in LED lines; hata_temizle fault-clear pulse;
//        faz (0 none,1 red,2 blue,3 green), faz_degisti entry pulse, son_sure last phase seconds,
//        dongu_sayisi completed cycles, hata sticky fault, hata_kodu first fault code.
// Optional: define KARARLILIK_FILTRE_EN to require FILTRE_LEN identical samples before a code reaches the FSM.
module trafik_isik_izleyici #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int KIRMIZI_SURE  = 10,
  parameter int MAVI_SURE     = 2,
  parameter int YESIL_SURE    = 5,
  parameter int TOLERANS      = 1,
  parameter int FILTRE_LEN    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kirmizi_in,
  input  logic        mavi_in,
  input  logic        yesil_in,
  input  logic        hata_temizle,
  output logic [1:0]  faz,
  output logic        faz_degisti,
  output logic [7:0]  son_sure,
  output logic [15:0] dongu_sayisi,
  output logic        hata,
  output logic [2:0]  hata_kodu
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [8:0] K_LO = 9'(KIRMIZI_SURE > TOLERANS ? KIRMIZI_SURE - TOLERANS : 0);
  localparam logic [8:0] M_LO = 9'(MAVI_SURE > TOLERANS ? MAVI_SURE - TOLERANS : 0);
  localparam logic [8:0] Y_LO = 9'(YESIL_SURE > TOLERANS ? YESIL_SURE - TOLERANS : 0);
  localparam logic [8:0] K_HI = 9'(KIRMIZI_SURE + TOLERANS + 1);
  localparam logic [8:0] M_HI = 9'(MAVI_SURE + TOLERANS + 1);
  localparam logic [8:0] Y_HI = 9'(YESIL_SURE + TOLERANS + 1);

  if (FILTRE_LEN < 1) begin : g_bad_filtre
    $error("FILTRE_LEN must be at least 1");
  end

  // Phase states share their encoding with the faz output value.
  typedef enum logic [2:0] {INIT = 3'd0, KIRMIZI = 3'd1, MAVI = 3'd2, YESIL = 3'd3, HATA = 3'd4} state_t;
  state_t state, nxt;
  logic [2:0] code_q, flt;
  logic [1:0] ph, code_ph, succ;
  logic [PW-1:0] presc;
  logic [7:0] sure_sn, meas;
  logic [8:0] lo, hi;
  logic wrap, accept, in_faz, dark, legal, gec;

`ifdef KARARLILIK_FILTRE_EN
  logic [2:0] hist [FILTRE_LEN];
  logic all_eq;
  always_comb begin
    all_eq = 1'b1;
    for (int i = 1; i < FILTRE_LEN; i++) all_eq = all_eq && (hist[i] == hist[0]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FILTRE_LEN; i++) hist[i] <= 3'd0;
      code_q <= 3'd0;
    end else begin
      hist[0] <= {kirmizi_in, mavi_in, yesil_in};
      for (int i = 1; i < FILTRE_LEN; i++) hist[i] <= hist[i-1];
      if (all_eq) code_q <= hist[0];
    end
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) code_q <= 3'd0;
    else code_q <= {kirmizi_in, mavi_in, yesil_in};
`endif

  assign in_faz  = state == KIRMIZI || state == MAVI || state == YESIL;
  assign ph      = state[1:0];
  assign code_ph = code_q == 3'b100 ? 2'd1 : code_q == 3'b010 ? 2'd2 : code_q == 3'b001 ? 2'd3 : 2'd0;
  assign dark    = code_q == 3'b000;
  assign legal   = code_ph != 2'd0;
  assign succ    = ph == 2'd3 ? 2'd1 : ph + 2'd1;
  assign lo      = ph == 2'd1 ? K_LO : ph == 2'd2 ? M_LO : Y_LO;
  assign hi      = ph == 2'd1 ? K_HI : ph == 2'd2 ? M_HI : Y_HI;
  assign wrap    = presc == PW'(TICKS_PER_SEC - 1);
  // Seconds including a tick landing on this edge, so a phase of exactly N seconds measures N.
  assign meas    = wrap && sure_sn != 8'hFF ? sure_sn + 8'd1 : sure_sn;
  assign gec     = {1'b0, sure_sn} >= hi;
  assign faz     = in_faz ? ph : 2'd0;
  assign hata    = state == HATA;

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    flt    = 3'd0;
    if (state == INIT) begin
      flt    = !legal && !dark ? 3'd1 : 3'd0;
      accept = legal;
    end else if (in_faz) begin
      flt    = !legal && !dark ? 3'd1 : dark ? 3'd2 : gec ? 3'd5 : code_ph == ph ? 3'd0 :
               code_ph != succ ? 3'd3 : {1'b0, meas} < lo ? 3'd4 : 3'd0;
      accept = flt == 3'd0 && code_ph != ph;
    end
    if (accept) nxt = state_t'({1'b0, code_ph});
    // A clear arriving with a fresh fault wins and drops straight back to INIT.
    if (flt != 3'd0) nxt = hata_temizle ? INIT : HATA;
    if (state == HATA && hata_temizle) nxt = INIT;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= INIT;
      faz_degisti  <= 1'b0;
      presc        <= '0;
      sure_sn      <= 8'd0;
      son_sure     <= 8'd0;
      dongu_sayisi <= 16'd0;
      hata_kodu    <= 3'd0;
    end else begin
      state       <= nxt;
      faz_degisti <= accept;
      presc       <= accept || !in_faz || wrap ? '0 : presc + 1'b1;
      sure_sn     <= accept || !in_faz ? 8'd0 : meas;
      if (accept && in_faz) son_sure <= meas;
      if (accept && state == YESIL) dongu_sayisi <= dongu_sayisi + 16'd1;
      hata_kodu   <= nxt != HATA ? 3'd0 : state == HATA ? hata_kodu : flt;
    end
endmodule
